// File: rtl/ifetch_unit.sv
// rtl/ifetch_unit.sv - in-order instruction fetch with credit-limited request queue and decode buffer
module ifetch_unit #(
    parameter int DEPTH = 4
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [31:0] i_pc,
    input  logic        i_flush,
    output logic        o_stall,
    output logic        o_imem_req,
    output logic [31:0] o_imem_addr,
    input  logic        i_imem_gnt,
    input  logic        i_imem_rvalid,
    input  logic [31:0] i_imem_rdata,
    input  logic        i_imem_err,
    output logic        o_instr_valid,
    output logic [31:0] o_instr,
    output logic [31:0] o_instr_pc,
    output logic        o_instr_err,
    input  logic        i_instr_ready
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW:0] CREDIT_MAX = (CW + 1)'(DEPTH);

    // outstanding queue: address of each request in flight plus its wrong-path flag
    logic [31:0]      oq_pc [DEPTH];
    logic [DEPTH-1:0] oq_kill;
    logic [AW-1:0]    oq_wr_ptr;
    logic [AW-1:0]    oq_rd_ptr;
    logic [CW-1:0]    out_cnt;

    // instruction buffer feeding decode
    logic [31:0]      if_instr [DEPTH];
    logic [31:0]      if_pc    [DEPTH];
    logic [DEPTH-1:0] if_err;
    logic [AW-1:0]    if_wr_ptr;
    logic [AW-1:0]    if_rd_ptr;
    logic [CW-1:0]    if_cnt;

    logic [CW:0]      credit_used;
    logic             credit_ok;
    logic             oq_push;
    logic             oq_pop;
    logic             if_push;
    logic             if_pop;

    // credit check uses registered counts only, so a pop frees credit one cycle later
    always_comb begin
        credit_used   = {1'b0, out_cnt} + {1'b0, if_cnt};
        credit_ok     = credit_used < CREDIT_MAX;
        o_imem_req    = i_rst_n & ~i_flush & credit_ok;
        o_imem_addr   = i_pc;
        oq_push       = o_imem_req & i_imem_gnt;
        o_stall       = ~i_rst_n | (~i_flush & ~oq_push);
        oq_pop        = i_imem_rvalid & (out_cnt != '0);
        if_push       = oq_pop & ~oq_kill[oq_rd_ptr] & ~i_flush;
        o_instr_valid = (if_cnt != '0) & ~i_flush;
        if_pop        = o_instr_valid & i_instr_ready;
        o_instr       = if_instr[if_rd_ptr];
        o_instr_pc    = if_pc[if_rd_ptr];
        o_instr_err   = if_err[if_rd_ptr];
    end

    // track accepted requests; a redirect marks everything in flight as wrong-path
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            oq_wr_ptr <= '0;
            oq_rd_ptr <= '0;
            out_cnt   <= '0;
            oq_kill   <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                oq_pc[i] <= '0;
            end
        end else begin
            if (oq_push) begin
                oq_pc[oq_wr_ptr]   <= i_pc;
                oq_kill[oq_wr_ptr] <= 1'b0;
                oq_wr_ptr          <= oq_wr_ptr + AW'(1);
            end
            if (oq_pop) begin
                oq_rd_ptr <= oq_rd_ptr + AW'(1);
            end
            // no push can coincide with a flush, so marking every slot is safe
            if (i_flush) begin
                oq_kill <= '1;
            end
            out_cnt <= out_cnt + CW'(oq_push) - CW'(oq_pop);
        end
    end

    // buffer live responses for decode; a redirect empties the buffer
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            if_wr_ptr <= '0;
            if_rd_ptr <= '0;
            if_cnt    <= '0;
            if_err    <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                if_instr[i] <= '0;
                if_pc[i]    <= '0;
            end
        end else if (i_flush) begin
            if_wr_ptr <= '0;
            if_rd_ptr <= '0;
            if_cnt    <= '0;
        end else begin
            if (if_push) begin
                if_instr[if_wr_ptr] <= i_imem_rdata;
                if_pc[if_wr_ptr]    <= oq_pc[oq_rd_ptr];
                if_err[if_wr_ptr]   <= i_imem_err;
                if_wr_ptr           <= if_wr_ptr + AW'(1);
            end
            if (if_pop) begin
                if_rd_ptr <= if_rd_ptr + AW'(1);
            end
            if_cnt <= if_cnt + CW'(if_push) - CW'(if_pop);
        end
    end
endmodule

// File: doc/ifetch_unit.md
Name: ifetch_unit

Overview:
- Consumer end of the program-counter interface.
- Takes the current fetch address from pc, issues in-order requests to instruction memory, and buffers returned instructions for decode.
- Drives the pc stall input so pc advances only when a fetch request is accepted.
- On redirect (branch taken or start-address load), kills wrong-path responses still in flight.

Parameters:
- DEPTH, 4, combined credit: outstanding memory requests plus buffered instructions; power of 2, ≥2.

Ports:
- i_clk  in  1  clock, rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_pc  in  32  current fetch address (pc register value)
- i_flush  in  1  redirect this cycle; top level drives it as branch_true OR writing_first_addr
- o_stall  out  1  to pc stall input; 0 lets pc advance this cycle
- o_imem_req  out  1  fetch request valid
- o_imem_addr  out  32  fetch address
- i_imem_gnt  in  1  request accepted this cycle
- i_imem_rvalid  in  1  response valid; responses return in order
- i_imem_rdata  in  32  instruction word
- i_imem_err  in  1  access fault for this response
- o_instr_valid  out  1  instruction available to decode
- o_instr  out  32  instruction word
- o_instr_pc  out  32  address the instruction was fetched from
- o_instr_err  out  1  access fault flag for this instruction
- i_instr_ready  in  1  decode accepts instruction

Behaviour:
- State:
  - Outstanding queue (OQ): DEPTH entries of {pc[31:0], kill}, count out_cnt.
  - Instruction FIFO (IF): DEPTH entries of {instr, pc, err}, count if_cnt.
  - Both use registered pointers and wrap modulo DEPTH.
- Reset (i_rst_n=0, asynchronous): pointers, counts and kill bits cleared. All outputs 0 except o_stall=1. Reset mid-transaction abandons in-flight responses; after reset, rvalid with out_cnt==0 is ignored.
- Request, combinational:
  - o_imem_req = i_rst_n & ~i_flush & (out_cnt + if_cnt < DEPTH).
  - o_imem_addr = i_pc.
  - Counts are registered values; same-cycle pops do not add credit.
- Accept: o_imem_req & i_imem_gnt pushes {i_pc, kill=0} into OQ at the clock edge.
- Stall: o_stall = ~i_flush & ~(o_imem_req & i_imem_gnt).
  - pc advances exactly once per accepted request.
  - pc always loads the redirect target in a flush cycle.
- Response: i_imem_rvalid with out_cnt>0 pops the OQ head.
  - If kill=0 and i_flush=0: push {rdata, head pc, err} into IF.
  - Otherwise discard.
  - rvalid with out_cnt==0 is ignored.
  - Earliest response is the cycle after grant.
  - IF cannot overflow because of the credit rule.
- Output:
  - o_instr_valid = (if_cnt>0) & ~i_flush.
  - o_instr, o_instr_pc and o_instr_err show the IF head.
  - Transfer when o_instr_valid & i_instr_ready; pops IF.
  - No bypass: response at cycle N is visible at the earliest at N+1.
  - Minimum grant-to-decode latency is 2 cycles.
- Flush at an edge:
  - IF emptied (if_cnt=0).
  - Every valid OQ entry has kill set; out_cnt unchanged.
  - Killed entries keep consuming credit until their responses arrive.
  - No request is issued in the flush cycle.
  - A response in the flush cycle is popped and discarded.
- Simultaneous events: one OQ push, one OQ pop, one IF push and one IF pop can occur in the same cycle. Counts update by net change.
- Throughput: DEPTH=4 with 1-cycle memory latency and decode always ready sustains 1 instruction per cycle.
- Misaligned addresses are pc's responsibility and are passed through unchecked.

Test Plan:
1. Reset, then i_pc=0x0, gnt=1, 1-cycle memory returning addr^0xA5A5A5A5, ready=1 -> o_instr_pc sequence 0x0, 0x4, 0x8… one per cycle after 2-cycle latency; o_stall=0 every cycle after the first grant.
2. ready=0, gnt=1, latency 1 -> exactly 4 requests accepted, then o_imem_req=0 and o_stall=1. Raising ready drains 0x0, 0x4, 0x8, 0xC in order, and requests resume only after a pop.
3. 3 requests outstanding (latency 3), i_flush pulse with pc redirected to 0x100 -> the 3 late responses are discarded. First o_instr_pc after flush is 0x100; no request is issued in the flush cycle.
4. Response with i_imem_err=1 for 0x8 -> o_instr_err=1 only with o_instr_pc=0x8, and the following instruction at 0xC has err=0.
5. Assert i_rst_n=0 asynchronously mid-burst (2 outstanding), then release -> outputs 0 immediately. A stray rvalid after release produces no o_instr_valid, and fetch restarts from the pc reset value 0x0.
6. gnt held 0 for 5 cycles -> o_imem_req=1 and o_stall=1 throughout with i_pc stable. The first grant advances pc by exactly 4.
